// File: rtl/segment_transition_ctl_pkg.sv
// Shared constants for the segment transition controller: request mode
// encodings, the "repeat forever" value and the mode-validity helper.
package segment_transition_ctl_pkg;

    localparam logic [2:0] TRANSITION_MODE_IMMEDIATE = 3'd0;
    localparam logic [2:0] TRANSITION_MODE_EXT       = 3'd1;
    localparam logic [2:0] TRANSITION_MODE_SYS_TIME  = 3'd2;
    localparam logic [2:0] TRANSITION_MODE_GPIO      = 3'd3;

    // All-ones repeat count means "loop forever"; sliced down to REP_W by users.
    localparam logic [63:0] REP_INFINITE = '1;

    // Modes 0-2 are always legal; mode 3 only when the GPIO trigger is built in.
    function automatic logic mode_is_valid(input logic [2:0] mode, input logic gpio_en);
        return (mode <= TRANSITION_MODE_SYS_TIME) ||
               (gpio_en && (mode == TRANSITION_MODE_GPIO));
    endfunction

endpackage

// File: rtl/segment_transition_ctl_edge_detect.sv
// Registered rising-edge detector: two-flop history of the input level,
// one-cycle pulse when the newer sample is high and the older one low.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic rise
);

    logic trig_p0;
    logic trig_p1;

    // Shift the trigger level through the two-flop history.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_p0 <= 1'b0;
            trig_p1 <= 1'b0;
        end else begin
            trig_p0 <= trig;
            trig_p1 <= trig_p0;
        end
    end

    assign rise = trig_p0 & ~trig_p1;

endmodule

// File: rtl/segment_transition_ctl.sv
// Segment transition controller: accepts a segment-change request in IDLE,
// waits for the selected trigger (immediate, loop end, system time or GPIO
// edge), swaps the active segment for one cycle and tracks the repeat count.
// Build option: define SEGMENT_GPIO_TRIG_EN to enable GPIO mode (mode 3);
// without it mode 3 is rejected as invalid and GPIO_TRIG is ignored.
module segment_transition_ctl #(
    parameter int REP_W  = 16,
    parameter int TIME_W = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    input  logic              REQ_SEGMENT,
    input  logic [2:0]        REQ_MODE,
    input  logic [TIME_W-1:0] REQ_TIME,
    input  logic [REP_W-1:0]  REQ_REP,
    input  logic [TIME_W-1:0] SYS_TIME,
    input  logic              CYCLE_END,
    input  logic              GPIO_TRIG,
    output logic              SEGMENT,
    output logic              REQ_READY,
    output logic              SWAP_DONE,
    output logic              STOP,
    output logic              ERR_LATE,
    output logic              ERR_MODE
);

    import segment_transition_ctl_pkg::*;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EXT,
        ST_WAIT_TIME,
        ST_WAIT_GPIO,
        ST_SWAP
    } state_t;

    localparam logic [REP_W-1:0] REP_INF = REP_INFINITE[REP_W-1:0];
    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

`ifdef SEGMENT_GPIO_TRIG_EN
    localparam logic GPIO_EN = 1'b1;
`else
    localparam logic GPIO_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              mode_ok;
    logic              late;
    logic              gpio_rise;
    logic              seg_q;
    logic [TIME_W-1:0] time_q;
    logic [REP_W-1:0]  rep_q;
    logic [REP_W-1:0]  rep_cnt;

`ifdef SEGMENT_GPIO_TRIG_EN
    edge_detect u_gpio_edge (
        .clk  (CLK),
        .rst  (RESET),
        .trig (GPIO_TRIG),
        .rise (gpio_rise)
    );
`else
    logic unused_gpio_trig;
    assign unused_gpio_trig = GPIO_TRIG;
    assign gpio_rise        = 1'b0;
`endif

    assign REQ_READY = (state == ST_IDLE);
    assign accept    = REQ_VALID && REQ_READY;
    assign mode_ok   = mode_is_valid(REQ_MODE, GPIO_EN);
    assign late      = (REQ_TIME < SYS_TIME);

    // State register; reset aborts any pending wait.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: pick the wait state from the request mode, leave it on the trigger.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (REQ_VALID && mode_ok) begin
                    case (REQ_MODE)
                        TRANSITION_MODE_IMMEDIATE: state_next = ST_SWAP;
                        TRANSITION_MODE_EXT:       state_next = ST_WAIT_EXT;
                        TRANSITION_MODE_SYS_TIME:  state_next = late ? ST_IDLE : ST_WAIT_TIME;
                        TRANSITION_MODE_GPIO:      state_next = ST_WAIT_GPIO;
                        default:                   state_next = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT_EXT: begin
                if (CYCLE_END) begin
                    state_next = ST_SWAP;
                end
            end
            ST_WAIT_TIME: begin
                if (SYS_TIME >= time_q) begin
                    state_next = ST_SWAP;
                end
            end
            ST_WAIT_GPIO: begin
                if (gpio_rise) begin
                    state_next = ST_SWAP;
                end
            end
            ST_SWAP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the request payload at acceptance; later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (accept) begin
            seg_q  <= REQ_SEGMENT;
            time_q <= REQ_TIME;
            rep_q  <= REQ_REP;
        end
    end

    // Segment swap, repeat counter and STOP; a swap reload wins over a coincident CYCLE_END.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SEGMENT   <= 1'b0;
            SWAP_DONE <= 1'b0;
            STOP      <= 1'b0;
            rep_cnt   <= REP_INF;
        end else begin
            SWAP_DONE <= (state == ST_SWAP);
            if (state == ST_SWAP) begin
                SEGMENT <= seg_q;
                rep_cnt <= rep_q;
                STOP    <= 1'b0;
            end else if (CYCLE_END && (rep_cnt != REP_INF)) begin
                if (rep_cnt != '0) begin
                    rep_cnt <= rep_cnt - REP_ONE;
                end
                if (rep_cnt <= REP_ONE) begin
                    STOP <= 1'b1;
                end
            end
        end
    end

    // Sticky request errors, refreshed by every accepted request with a legal mode.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ERR_LATE <= 1'b0;
            ERR_MODE <= 1'b0;
        end else if (accept) begin
            if (!mode_ok) begin
                ERR_MODE <= 1'b1;
            end else begin
                ERR_MODE <= 1'b0;
                ERR_LATE <= (REQ_MODE == TRANSITION_MODE_SYS_TIME) && late;
            end
        end
    end

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl with a swap scoreboard.
module tb_segment_transition_ctl;

    localparam int REP_W  = 16;
    localparam int TIME_W = 64;

    logic              CLK;
    logic              RESET;
    logic              REQ_VALID;
    logic              REQ_SEGMENT;
    logic [2:0]        REQ_MODE;
    logic [TIME_W-1:0] REQ_TIME;
    logic [REP_W-1:0]  REQ_REP;
    logic [TIME_W-1:0] SYS_TIME;
    logic              CYCLE_END;
    logic              GPIO_TRIG;
    logic              SEGMENT;
    logic              REQ_READY;
    logic              SWAP_DONE;
    logic              STOP;
    logic              ERR_LATE;
    logic              ERR_MODE;

    segment_transition_ctl #(.REP_W(REP_W), .TIME_W(TIME_W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ_VALID   (REQ_VALID),
        .REQ_SEGMENT (REQ_SEGMENT),
        .REQ_MODE    (REQ_MODE),
        .REQ_TIME    (REQ_TIME),
        .REQ_REP     (REQ_REP),
        .SYS_TIME    (SYS_TIME),
        .CYCLE_END   (CYCLE_END),
        .GPIO_TRIG   (GPIO_TRIG),
        .SEGMENT     (SEGMENT),
        .REQ_READY   (REQ_READY),
        .SWAP_DONE   (SWAP_DONE),
        .STOP        (STOP),
        .ERR_LATE    (ERR_LATE),
        .ERR_MODE    (ERR_MODE)
    );

    localparam logic [2:0] M_IMM  = 3'd0;
    localparam logic [2:0] M_EXT  = 3'd1;
    localparam logic [2:0] M_SYS  = 3'd2;
    localparam logic [2:0] M_GPIO = 3'd3;
    localparam logic [REP_W-1:0] REP_FOREVER = 16'hFFFF;

    typedef struct {
        logic seg;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic tick_time(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            SYS_TIME = SYS_TIME + 1;
        end
    endtask

    task automatic drive_req(input logic seg, input logic [2:0] mode,
                             input logic [TIME_W-1:0] t, input logic [REP_W-1:0] rep);
        REQ_SEGMENT = seg;
        REQ_MODE    = mode;
        REQ_TIME    = t;
        REQ_REP     = rep;
        REQ_VALID   = 1'b1;
    endtask

    task automatic send(input logic seg, input logic [2:0] mode,
                        input logic [TIME_W-1:0] t, input logic [REP_W-1:0] rep);
        drive_req(seg, mode, t, rep);
        tick(1);
        REQ_VALID = 1'b0;
    endtask

    task automatic expect_swap(input logic seg, input int at);
        exp_t e;
        e.seg = seg;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic pulse_cycle_end();
        CYCLE_END = 1'b1;
        tick(1);
        CYCLE_END = 1'b0;
    endtask

    // Scoreboard: every SWAP_DONE pulse must match the oldest expected swap.
    always @(negedge CLK) begin
        if (SWAP_DONE === 1'b1) begin
            chk("swap_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("swap_segment", SEGMENT, e.seg);
                chk("swap_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET       = 1'b1;
        REQ_VALID   = 1'b0;
        REQ_SEGMENT = 1'b0;
        REQ_MODE    = 3'd0;
        REQ_TIME    = '0;
        REQ_REP     = '0;
        SYS_TIME    = '0;
        CYCLE_END   = 1'b0;
        GPIO_TRIG   = 1'b0;
        tick(2);
        chk("rst_segment", SEGMENT, 0);
        chk("rst_ready", REQ_READY, 1);
        chk("rst_swap_done", SWAP_DONE, 0);
        chk("rst_stop", STOP, 0);
        chk("rst_err_late", ERR_LATE, 0);
        chk("rst_err_mode", ERR_MODE, 0);
        RESET = 1'b0;
        tick(1);

        // IMMEDIATE to segment 1 with two loops, then STOP.
        expect_swap(1'b1, cyc + 2);
        send(1'b1, M_IMM, 0, 2);
        chk("imm_ready_in_swap", REQ_READY, 0);
        tick(1);
        chk("imm_segment", SEGMENT, 1);
        chk("imm_stop_after_swap", STOP, 0);
        chk("imm_ready_back", REQ_READY, 1);
        pulse_cycle_end();
        chk("imm_stop_after_1", STOP, 0);
        pulse_cycle_end();
        chk("imm_stop_after_2", STOP, 1);
        pulse_cycle_end();
        chk("imm_stop_held", STOP, 1);

        // SYS_TIME deadline already passed.
        SYS_TIME = 10;
        send(1'b0, M_SYS, 5, 7);
        chk("late_err", ERR_LATE, 1);
        chk("late_ready", REQ_READY, 1);
        chk("late_segment", SEGMENT, 1);
        chk("late_err_mode", ERR_MODE, 0);
        tick(2);

        // SYS_TIME deadline 1000 with time counting up from 990, infinite repeat.
        SYS_TIME = 990;
        expect_swap(1'b0, cyc + 12);
        drive_req(1'b0, M_SYS, 1000, REP_FOREVER);
        tick_time(1);
        REQ_VALID = 1'b0;
        chk("time_err_late_cleared", ERR_LATE, 0);
        chk("time_waiting", REQ_READY, 0);
        tick_time(11);
        chk("time_segment", SEGMENT, 0);
        chk("time_stop_cleared", STOP, 0);
        pulse_cycle_end();
        pulse_cycle_end();
        pulse_cycle_end();
        chk("infinite_no_stop", STOP, 0);

        // EXT to segment 1: CYCLE_END in the acceptance cycle must not count,
        // and the CYCLE_END coincident with the swap must not eat the new count.
        drive_req(1'b1, M_EXT, 0, 1);
        CYCLE_END = 1'b1;
        tick(1);
        REQ_VALID = 1'b0;
        CYCLE_END = 1'b0;
        tick(3);
        chk("ext_still_waiting", REQ_READY, 0);
        chk("ext_segment_old", SEGMENT, 0);
        expect_swap(1'b1, cyc + 2);
        CYCLE_END = 1'b1;
        tick(2);
        CYCLE_END = 1'b0;
        chk("ext_segment_new", SEGMENT, 1);
        chk("ext_stop_after_swap", STOP, 0);
        pulse_cycle_end();
        chk("ext_stop_after_1", STOP, 1);

        // Reset while waiting on a deadline aborts without a swap.
        SYS_TIME = 100;
        send(1'b0, M_SYS, 5000, 3);
        chk("abort_waiting", REQ_READY, 0);
        tick(2);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        chk("abort_segment", SEGMENT, 0);
        chk("abort_ready", REQ_READY, 1);
        chk("abort_stop", STOP, 0);
        chk("abort_swap_done", SWAP_DONE, 0);
        SYS_TIME = 6000;
        tick(3);
        chk("abort_ready_later", REQ_READY, 1);

        // Invalid mode 5.
        send(1'b1, 3'd5, 0, 0);
        chk("mode5_err", ERR_MODE, 1);
        chk("mode5_ready", REQ_READY, 1);
        chk("mode5_segment", SEGMENT, 0);
        tick(2);

        // A valid request clears ERR_MODE.
        expect_swap(1'b1, cyc + 2);
        send(1'b1, M_IMM, 0, REP_FOREVER);
        chk("err_mode_cleared", ERR_MODE, 0);
        tick(1);
        chk("clear_segment", SEGMENT, 1);

        // Request for the segment already active still swaps and reloads the count.
        expect_swap(1'b1, cyc + 2);
        send(1'b1, M_IMM, 0, 1);
        tick(1);
        chk("same_seg_segment", SEGMENT, 1);
        chk("same_seg_stop", STOP, 0);
        pulse_cycle_end();
        chk("same_seg_stop_after_1", STOP, 1);

`ifdef SEGMENT_GPIO_TRIG_EN
        // GPIO held high at acceptance is history, not an edge.
        GPIO_TRIG = 1'b1;
        tick(3);
        send(1'b0, M_GPIO, 0, 3);
        chk("gpio_waiting", REQ_READY, 0);
        chk("gpio_err_mode", ERR_MODE, 0);
        tick(3);
        send(1'b1, M_IMM, 0, 2);
        chk("gpio_drop_ready", REQ_READY, 0);
        GPIO_TRIG = 1'b0;
        tick(2);
        expect_swap(1'b0, cyc + 3);
        GPIO_TRIG = 1'b1;
        tick(3);
        chk("gpio_segment", SEGMENT, 0);
        chk("gpio_stop_cleared", STOP, 0);
`else
        // Without the GPIO option, mode 3 is invalid.
        send(1'b0, M_GPIO, 0, 3);
        chk("gpio_off_err_mode", ERR_MODE, 1);
        chk("gpio_off_ready", REQ_READY, 1);
        chk("gpio_off_segment", SEGMENT, 1);
        tick(2);
`endif

        tick(3);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
